// File: rtl/systolic_mm_if.sv
// Operand/result handshake bundle for systolic_mm: operand beats in, result rows out.
interface systolic_mm_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) ();
    logic [N*DATA_W-1:0] a_col_i;
    logic [N*DATA_W-1:0] b_row_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [N*ACC_W-1:0]  c_row_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                out_last_o;
    logic                busy_o;

    modport slave (
        input  a_col_i, b_row_i, in_valid_i, out_ready_i,
        output in_ready_o, c_row_o, out_valid_o, out_last_o, busy_o
    );

    modport master (
        output a_col_i, b_row_i, in_valid_i, out_ready_i,
        input  in_ready_o, c_row_o, out_valid_o, out_last_o, busy_o
    );
endinterface

// File: rtl/systolic_mm.sv
// Output-stationary N x N systolic matrix multiplier (C = A x B), one operand beat per k.
// Define SYSTOLIC_MM_SAT_EN to make accumulators saturate instead of wrapping.
module systolic_mm #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    systolic_mm_if.slave  bus
);
    localparam int CNT_W = $clog2(2*N) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N-1);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(N-1);
    localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(2*N-2);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] beat_reg, flush_reg, row_reg;
    logic             in_ready_reg, out_valid_reg, out_last_reg, busy_reg;
    logic             accept, drain_hs, acc_clr;

    assign accept   = bus.in_valid_i && in_ready_reg;
    assign drain_hs = out_valid_reg && bus.out_ready_i;
    assign acc_clr  = drain_hs && out_last_reg;

    assign bus.in_ready_o  = in_ready_reg;
    assign bus.out_valid_o = out_valid_reg;
    assign bus.out_last_o  = out_last_reg;
    assign bus.busy_o      = busy_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            flush_reg     <= '0;
            row_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        busy_reg <= 1'b1;
                        beat_reg <= CNT_W'(1);
                        if (N == 1) begin
                            state_reg    <= FLUSH;
                            in_ready_reg <= 1'b0;
                            flush_reg    <= '0;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (beat_reg == LAST_BEAT) begin
                            state_reg    <= FLUSH;
                            in_ready_reg <= 1'b0;
                            flush_reg    <= '0;
                        end else begin
                            beat_reg <= beat_reg + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Last product reaches PE(N-1,N-1) 2N-1 cycles after the final beat.
                    if (flush_reg == FLUSH_END) begin
                        state_reg     <= DRAIN;
                        out_valid_reg <= 1'b1;
                        row_reg       <= '0;
                        out_last_reg  <= (N == 1);
                    end else begin
                        flush_reg <= flush_reg + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (out_last_reg) begin
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            row_reg       <= '0;
                            beat_reg      <= '0;
                        end else begin
                            row_reg      <= row_reg + CNT_W'(1);
                            out_last_reg <= ((row_reg + CNT_W'(1)) == LAST_ROW);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // a_hop[i][j] / b_hop[i][j] are the operands entering PE(i,j).
    logic [DATA_W-1:0] a_hop [N][N];
    logic [DATA_W-1:0] b_hop [N][N];
    logic [ACC_W-1:0]  acc_w [N][N];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            logic [DATA_W-1:0] a_feed, b_feed;
            // Idle cycles push zeros so bubbles contribute nothing to the sums.
            assign a_feed = accept ? bus.a_col_i[(N-1-gi)*DATA_W +: DATA_W] : '0;
            assign b_feed = accept ? bus.b_row_i[(N-1-gi)*DATA_W +: DATA_W] : '0;
            if (gi == 0) begin : g_nodly
                assign a_hop[0][0] = a_feed;
                assign b_hop[0][0] = b_feed;
            end else begin : g_dly
                logic [DATA_W-1:0] a_dly_reg [gi];
                logic [DATA_W-1:0] b_dly_reg [gi];
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        for (int s = 0; s < gi; s++) begin
                            a_dly_reg[s] <= '0;
                            b_dly_reg[s] <= '0;
                        end
                    end else begin
                        a_dly_reg[0] <= a_feed;
                        b_dly_reg[0] <= b_feed;
                        for (int s = 1; s < gi; s++) begin
                            a_dly_reg[s] <= a_dly_reg[s-1];
                            b_dly_reg[s] <= b_dly_reg[s-1];
                        end
                    end
                end
                assign a_hop[gi][0] = a_dly_reg[gi-1];
                assign b_hop[0][gi] = b_dly_reg[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_pe
                logic [DATA_W-1:0]   a_reg, b_reg;
                logic [ACC_W-1:0]    acc_reg, acc_nxt;
                logic [2*DATA_W-1:0] prod;

                assign prod = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, b_reg};
`ifdef SYSTOLIC_MM_SAT_EN
                logic [ACC_W:0] sum;
                assign sum     = {1'b0, acc_reg} + (ACC_W+1)'(prod);
                assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                assign acc_nxt = acc_reg + ACC_W'(prod);
`endif
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        a_reg   <= '0;
                        b_reg   <= '0;
                        acc_reg <= '0;
                    end else begin
                        a_reg   <= a_hop[gi][gj];
                        b_reg   <= b_hop[gi][gj];
                        acc_reg <= acc_clr ? '0 : acc_nxt;
                    end
                end

                if (gj < N-1) begin : g_a_fwd
                    assign a_hop[gi][gj+1] = a_reg;
                end
                if (gi < N-1) begin : g_b_fwd
                    assign b_hop[gi+1][gj] = b_reg;
                end
                assign acc_w[gi][gj] = acc_reg;
            end
        end

        for (gj = 0; gj < N; gj++) begin : g_out
            logic [ACC_W-1:0] col_sel;
            always_comb begin
                col_sel = '0;
                for (int i = 0; i < N; i++) begin
                    if (row_reg == CNT_W'(i)) col_sel = acc_w[i][gj];
                end
            end
            assign bus.c_row_o[(N-1-gj)*ACC_W +: ACC_W] = out_valid_reg ? col_sel : '0;
        end
    endgenerate
endmodule

// File: tb/tb_systolic_mm.sv
// Self-checking bench for systolic_mm: two N=4 instances (32- and 16-bit accumulators) in lockstep plus an N=1 instance.
module tb_systolic_mm;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_mm_if #(.N(4), .DATA_W(8), .ACC_W(32)) bus4 ();
    systolic_mm_if #(.N(4), .DATA_W(8), .ACC_W(16)) bus16 ();
    systolic_mm_if #(.N(1), .DATA_W(8), .ACC_W(32)) bus1 ();

    systolic_mm #(.N(4), .DATA_W(8), .ACC_W(32)) u_dut4  (.clk_i(clk), .rst_ni(rst_n), .bus(bus4));
    systolic_mm #(.N(4), .DATA_W(8), .ACC_W(16)) u_dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16));
    systolic_mm #(.N(1), .DATA_W(8), .ACC_W(32)) u_dut1  (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

    logic [31:0] a_col, b_col;
    logic        in_valid, out_ready;
    logic [7:0]  a1, b1;
    logic        v1, r1;

    assign bus4.a_col_i     = a_col;
    assign bus4.b_row_i     = b_col;
    assign bus4.in_valid_i  = in_valid;
    assign bus4.out_ready_i = out_ready;
    assign bus16.a_col_i     = a_col;
    assign bus16.b_row_i     = b_col;
    assign bus16.in_valid_i  = in_valid;
    assign bus16.out_ready_i = out_ready;
    assign bus1.a_col_i     = a1;
    assign bus1.b_row_i     = b1;
    assign bus1.in_valid_i  = v1;
    assign bus1.out_ready_i = r1;

    int checks = 0;
    int errors = 0;
    int unsigned ma [4][4];
    int unsigned mb [4][4];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain dot products, then the accumulator width rule.
    function automatic longint unsigned model_c(int i, int j, int accw);
        longint unsigned s = 0;
        longint unsigned mx = (64'd1 << accw) - 64'd1;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
`ifdef SYSTOLIC_MM_SAT_EN
        if (s > mx) s = mx;
`else
        s = s & mx;
`endif
        return s;
    endfunction

    function automatic logic [127:0] exp_row(int r, int accw);
        logic [127:0] row = '0;
        longint unsigned v;
        for (int j = 0; j < N; j++) begin
            v = model_c(r, j, accw);
            if (accw == 32) row[(N-1-j)*32 +: 32] = v[31:0];
            else            row[(N-1-j)*16 +: 16] = v[15:0];
        end
        return row;
    endfunction

    function automatic logic [31:0] pack_a(int k);
        logic [31:0] p;
        int unsigned e;
        for (int i = 0; i < N; i++) begin
            e = ma[i][k];
            p[(N-1-i)*8 +: 8] = e[7:0];
        end
        return p;
    endfunction

    function automatic logic [31:0] pack_b(int k);
        logic [31:0] p;
        int unsigned e;
        for (int j = 0; j < N; j++) begin
            e = mb[k][j];
            p[(N-1-j)*8 +: 8] = e[7:0];
        end
        return p;
    endfunction

    // All tasks start and end positioned just after a falling edge.
    task automatic feed(input int bub);
        int  k = 0;
        int  cyc = 0;
        logic v;
        while (k < N && cyc < 200) begin
            case (bub)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(1));
            endcase
            in_valid = v;
            if (v) begin
                a_col = pack_a(k);
                b_col = pack_b(k);
                check("in_ready_load", 128'(bus4.in_ready_o), 128'(1));
                if (bus4.in_ready_o) k++;
            end else begin
                a_col = $urandom;
                b_col = $urandom;
            end
            cyc++;
            @(negedge clk);
        end
        check("beats_accepted", 128'(k), 128'(N));
        in_valid = 1'b0;
        check("in_ready_drop", 128'(bus4.in_ready_o), 128'(0));
        check("in_ready_drop16", 128'(bus16.in_ready_o), 128'(0));
        check("busy_flush", 128'(bus4.busy_o), 128'(1));
    endtask

    task automatic flush_wait(input bit junk);
        int f = 0;
        while (!bus4.out_valid_o && f < 100) begin
            f++;
            if (junk) begin
                in_valid = 1'($urandom_range(1));
                a_col = $urandom;
                b_col = $urandom;
            end
            @(negedge clk);
        end
        check("flush_cycles", 128'(f), 128'(2*N-1));
    endtask

    task automatic drain(input int bp, input bit rbp, input bit junk);
        int r = 0, hs = 0, held = 0, g = 0;
        logic rdy;
        while (r < N && g < 200) begin
            g++;
            check("out_valid", 128'(bus4.out_valid_o), 128'(1));
            check("out_last", 128'(bus4.out_last_o), 128'(r == N-1));
            check("in_ready_drain", 128'(bus4.in_ready_o), 128'(0));
            check("c_row32", bus4.c_row_o, exp_row(r, 32));
            check("c_row16", 128'(bus16.c_row_o), exp_row(r, 16));
            if (r == 0 && held < bp) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = rbp ? 1'($urandom_range(1)) : 1'b1;
            end
            out_ready = rdy;
            if (junk) begin
                in_valid = 1'($urandom_range(1));
                a_col = $urandom;
                b_col = $urandom;
            end
            if (rdy) begin
                hs++;
                r++;
            end
            @(negedge clk);
        end
        check("handshakes", 128'(hs), 128'(N));
        out_ready = 1'b1;
        in_valid = 1'b0;
        check("idle_busy", 128'(bus4.busy_o), 128'(0));
        check("idle_in_ready", 128'(bus4.in_ready_o), 128'(1));
        check("idle_out_valid", 128'(bus4.out_valid_o), 128'(0));
        check("idle_out_last", 128'(bus4.out_last_o), 128'(0));
    endtask

    task automatic job(input string name, input int bub, input int bp, input bit rbp, input bit junk);
        feed(bub);
        flush_wait(junk);
        drain(bp, rbp, junk);
        $display("job %s: C[0][0]=%0d C[3][3]=%0d checks=%0d errors=%0d",
                 name, model_c(0, 0, 32), model_c(3, 3, 32), checks, errors);
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0:       begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = 4*i + j + 1; end
                    1:       begin ma[i][j] = 255; mb[i][j] = 255; end
                    2:       begin ma[i][j] = 1; mb[i][j] = 1; end
                    default: begin ma[i][j] = $urandom_range(255); mb[i][j] = $urandom_range(255); end
                endcase
            end
        end
    endtask

    initial begin
        int f;
        in_valid = 1'b0; out_ready = 1'b1; a_col = '0; b_col = '0;
        v1 = 1'b0; r1 = 1'b1; a1 = '0; b1 = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(bus4.in_ready_o), 128'(0));
        check("rst_busy", 128'(bus4.busy_o), 128'(0));
        check("rst_out_valid", 128'(bus4.out_valid_o), 128'(0));
        check("rst_out_last", 128'(bus4.out_last_o), 128'(0));
        check("rst_c_row", bus4.c_row_o, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 128'(bus4.in_ready_o), 128'(1));

        fill(0);
        job("identity", 0, 0, 1'b0, 1'b0);
        job("identity_bubbles", 1, 0, 1'b0, 1'b0);
        fill(1);
        job("all255_backpressure", 0, 5, 1'b0, 1'b0);

        fill(3);
        feed(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(bus4.busy_o), 128'(0));
        check("midrst_in_ready", 128'(bus4.in_ready_o), 128'(0));
        check("midrst_out_valid", 128'(bus4.out_valid_o), 128'(0));
        check("midrst_c_row", bus4.c_row_o, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 128'(bus4.in_ready_o), 128'(1));
        fill(2);
        job("ones_after_reset", 0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill(3);
            job($sformatf("random%0d", t), 2, $urandom_range(3), 1'b1, 1'b1);
        end

        for (int t = 0; t < 3; t++) begin
            a1 = (t == 0) ? 8'd3 : 8'($urandom_range(255));
            b1 = (t == 0) ? 8'd5 : 8'($urandom_range(255));
            v1 = 1'b1;
            check("n1_in_ready", 128'(bus1.in_ready_o), 128'(1));
            @(negedge clk);
            v1 = 1'b0;
            check("n1_in_ready_drop", 128'(bus1.in_ready_o), 128'(0));
            f = 0;
            while (!bus1.out_valid_o && f < 20) begin
                f++;
                @(negedge clk);
            end
            check("n1_flush_cycles", 128'(f), 128'(1));
            r1 = (t != 1);
            if (t == 1) begin
                @(negedge clk);
                check("n1_held_valid", 128'(bus1.out_valid_o), 128'(1));
                r1 = 1'b1;
            end
            check("n1_out_last", 128'(bus1.out_last_o), 128'(1));
            check("n1_c", bus1.c_row_o, 128'(int'(a1) * int'(b1)));
            @(negedge clk);
            check("n1_idle_busy", 128'(bus1.busy_o), 128'(0));
            check("n1_idle_valid", 128'(bus1.out_valid_o), 128'(0));
            $display("job n1_%0d: %0d*%0d checks=%0d errors=%0d", t, a1, b1, checks, errors);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_mm.md
SYSTOLIC_MM -- requirements
Module: systolic_mm

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N x N PEs, N >= 1).
REQ-002 SHALL have parameter DATA_W, default 8, meaning unsigned operand width.
REQ-003 SHALL have parameter ACC_W, default 32, meaning accumulator and result width (ACC_W >= 2*DATA_W).
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all state is rising-edge.
REQ-005 SHALL have port rst_ni  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port a_col_i  input  N*DATA_W  meaning A[i][k] for beat k, row i at bits [(N-1-i)*DATA_W +: DATA_W].
REQ-007 SHALL have port b_row_i  input  N*DATA_W  meaning B[k][j] for beat k, column j at bits [(N-1-j)*DATA_W +: DATA_W].
REQ-008 SHALL have port in_valid_i  input  1  meaning operand beat present.
REQ-009 SHALL have port in_ready_o  output  1  meaning operand beat accepted when high with in_valid_i.
REQ-010 SHALL have port c_row_o  output  N*ACC_W  meaning C[r][j] at bits [(N-1-j)*ACC_W +: ACC_W].
REQ-011 SHALL have port out_valid_o  output  1  meaning c_row_o holds a result row.
REQ-012 SHALL have port out_ready_i  input  1  meaning consumer takes the row.
REQ-013 SHALL have port out_last_o  output  1  meaning current row is r = N-1.
REQ-014 SHALL have port busy_o  output  1  meaning state is not IDLE.

Function
REQ-015 SHALL compute C = A x B, C[i][j] = sum over k of A[i][k]*B[k][j], output-stationary, product zero-extended to ACC_W.
REQ-016 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
REQ-017 SHALL drive in_ready_o = 1 in IDLE and LOAD only; an accepted beat in IDLE moves to LOAD and counts as beat 0.
REQ-018 SHALL count exactly N accepted beats; acceptance of beat N-1 moves to FLUSH next cycle (N=1: IDLE -> FLUSH directly).
REQ-019 SHALL skew operands internally: row i of A delayed i cycles, column j of B delayed j cycles, with a one-register hop per PE.
REQ-020 SHALL inject zero operands into the skew on every LOAD cycle where in_valid_i is low; bubbles do not corrupt results.
REQ-021 SHALL hold FLUSH for exactly 2N-1 cycles, then enter DRAIN.
REQ-022 SHALL in DRAIN assert out_valid_o with c_row_o = row r, starting r=0, advancing r on out_valid_o && out_ready_i.
REQ-023 SHALL keep c_row_o and r stable while out_ready_i is low.
REQ-024 SHALL assert out_last_o only when out_valid_o is high and r = N-1.
REQ-025 SHALL on the r = N-1 handshake clear all accumulators and return to IDLE the next cycle; in_ready_o stays low that cycle.
REQ-026 SHALL ignore in_valid_i and operand data outside IDLE/LOAD.
REQ-027 SHALL wrap accumulation modulo 2^ACC_W when the saturation feature is compiled out.

Reset
REQ-028 SHALL on rst_ni low immediately enter IDLE, zero all accumulators, skew registers, and beat/row counters, including mid-LOAD, FLUSH, or DRAIN.
REQ-029 SHALL hold outputs in reset: in_ready_o=0, out_valid_o=0, out_last_o=0, busy_o=0, c_row_o=0; in_ready_o rises in the first cycle after release.

Configuration
REQ-030 SHALL, with SYSTOLIC_MM_SAT_EN defined, saturate each accumulator at 2^ACC_W-1 (sticky until cleared).
REQ-031 SHALL, without SYSTOLIC_MM_SAT_EN, build no saturation logic and use REQ-027 wrap behaviour.

Verification
REQ-032 SHALL cover identity: N=4, A=I, B[k][j]=4k+j+1, back-to-back beats, out_ready_i=1 -> rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, out_last_o on row 3, 2N-1=7 FLUSH cycles measured.
REQ-033 SHALL cover bubbles: same data with in_valid_i low on alternate cycles -> identical C; in_ready_o drops exactly after 4th acceptance.
REQ-034 SHALL cover backpressure: all-255 A and B, out_ready_i low 5 cycles in DRAIN -> row 0 held stable, every C = 260100, 4 handshakes total.
REQ-035 SHALL cover reset mid-FLUSH: rst_ni low 1 cycle -> IDLE, busy_o=0; a fresh multiply of all-ones gives every C = 4 (no stale sums).
REQ-036 SHALL cover overflow: ACC_W=16, DATA_W=8, all-255 -> C = 260100 mod 65536 = 63492 without SYSTOLIC_MM_SAT_EN, 65535 with it.
REQ-037 SHALL cover back-to-back jobs and N=1: second job starts 1 cycle after last handshake with correct results; N=1, A=3, B=5 -> C=15, FLUSH 1 cycle.
